// File: rtl/lcd_hd44780_responder.sv
`default_nettype none
// ============================================================================
// Module   : lcd_hd44780_responder
// Purpose  : HD44780-compatible receiver for the character-LCD pin bus.
//            Synchronises LCD_EN/RS/RW/DATA, accepts write strobes on the
//            falling edge of EN, decodes instructions and character writes,
//            and keeps a 2x16 character buffer that can be read back.
// Ports    : clock        - system clock, rising edge
//            iRST_N       - asynchronous active-low reset
//            LCD_DATA/RS/RW/EN - LCD pin bus (inputs, asynchronous)
//            rd_addr      - buffer read index (0-15 line 1, 16-31 line 2)
//            rd_data      - registered buffer[rd_addr]
//            cursor_addr  - current DDRAM address
//            disp_on      - D bit of last display-control instruction
//            entry_inc    - I/D bit of last entry-mode instruction
//            busy         - strobes are not accepted while high
//            ovr_err      - sticky, strobe arrived while busy
//            frame_done   - one-cycle pulse after a write to index 31
// Revision : 1.0 - initial release
// ============================================================================
module lcd_hd44780_responder #(
    parameter int BUSY_CYCLES = 16
) (
    input  logic       clock,
    input  logic       iRST_N,
    input  logic [7:0] LCD_DATA,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_EN,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [6:0] cursor_addr,
    output logic       disp_on,
    output logic       entry_inc,
    output logic       busy,
    output logic       ovr_err,
    output logic       frame_done
);

    // Counter only has to hold BUSY_CYCLES-1.
    localparam int             c_cnt_w    = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(BUSY_CYCLES - 1);
    localparam logic [7:0]     c_space    = 8'h20;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_clear = 2'd1;
    localparam logic [1:0] c_st_busy  = 2'd2;

    // Synchroniser and edge-detect flops
    logic             r_en_s1, r_en_s2, r_en_s3;
    logic             r_rs_s1, r_rs_s2;
    logic             r_rw_s1, r_rw_s2;
    logic [7:0]       r_data_s1, r_data_s2;

    logic [1:0]       r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [4:0]       r_fill;
    logic [7:0]       r_buf [32];
    logic [7:0]       r_rd_data;
    logic [6:0]       r_cursor;
    logic             r_disp_on;
    logic             r_entry_inc;
    logic             r_busy;
    logic             r_ovr_err;
    logic             r_frame_done;

    logic             w_fall;
    logic             w_accept;
    logic             w_overrun;
    logic             w_wr_hit;
    logic [4:0]       w_wr_idx;

    // Cursor step with the HD44780 two-line wrap points.
    function automatic logic [6:0] f_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27)      return 7'h40;
            else if (a == 7'h67) return 7'h00;
            else                 return a + 7'd1;
        end else begin
            if (a == 7'h00)      return 7'h67;
            else if (a == 7'h40) return 7'h27;
            else                 return a - 7'd1;
        end
    endfunction

    // RS/RW/DATA are taken from the same stage as the current EN sample.
    assign w_fall    = r_en_s3 & ~r_en_s2;
    assign w_accept  = w_fall & ~r_rw_s2 & (r_state == c_st_idle);
    // Using the pre-edge state makes a strobe on the busy-ending edge an overrun.
    assign w_overrun = w_fall & ~r_rw_s2 & (r_state != c_st_idle);

    // Line 1 is 0x00-0x0F, line 2 is 0x40-0x4F; everything else is off-screen.
    assign w_wr_hit  = (r_cursor[6:4] == 3'b000) || (r_cursor[6:4] == 3'b100);
    assign w_wr_idx  = {r_cursor[6], r_cursor[3:0]};

    always_ff @(posedge clock or negedge iRST_N) begin
        if (!iRST_N) begin
            r_en_s1      <= 1'b0;
            r_en_s2      <= 1'b0;
            r_en_s3      <= 1'b0;
            r_rs_s1      <= 1'b0;
            r_rs_s2      <= 1'b0;
            r_rw_s1      <= 1'b0;
            r_rw_s2      <= 1'b0;
            r_data_s1    <= 8'h00;
            r_data_s2    <= 8'h00;
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_fill       <= 5'd0;
            for (int i = 0; i < 32; i++) begin
                r_buf[i] <= c_space;
            end
            r_rd_data    <= c_space;
            r_cursor     <= 7'h00;
            r_disp_on    <= 1'b0;
            r_entry_inc  <= 1'b1;
            r_busy       <= 1'b0;
            r_ovr_err    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_en_s1      <= LCD_EN;
            r_en_s2      <= r_en_s1;
            r_en_s3      <= r_en_s2;
            r_rs_s1      <= LCD_RS;
            r_rs_s2      <= r_rs_s1;
            r_rw_s1      <= LCD_RW;
            r_rw_s2      <= r_rw_s1;
            r_data_s1    <= LCD_DATA;
            r_data_s2    <= r_data_s1;

            r_rd_data    <= r_buf[rd_addr];
            r_frame_done <= 1'b0;

            if (w_overrun) begin
                r_ovr_err <= 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_state <= c_st_busy;
                        r_cnt   <= c_cnt_load;
                        r_busy  <= 1'b1;
                        if (!r_rs_s2) begin
                            casez (r_data_s2)
                                8'b1???????: r_cursor <= r_data_s2[6:0];
                                8'b01??????: ;
                                8'b001?????: ;
                                8'b0001????: begin
                                    // S = 1 is a display shift, which has no buffer effect here.
                                    if (!r_data_s2[3]) begin
                                        r_cursor <= f_step(r_cursor, r_data_s2[2]);
                                    end
                                end
                                8'b00001???: r_disp_on   <= r_data_s2[2];
                                8'b000001??: r_entry_inc <= r_data_s2[1];
                                8'b0000001?: r_cursor    <= 7'h00;
                                8'b00000001: begin
                                    r_state <= c_st_clear;
                                    r_fill  <= 5'd0;
                                end
                                default: ;
                            endcase
                        end else begin
                            if (w_wr_hit) begin
                                r_buf[w_wr_idx] <= r_data_s2;
                                r_frame_done    <= (w_wr_idx == 5'd31);
                            end
                            // Off-screen writes are dropped but still move the cursor.
                            r_cursor <= f_step(r_cursor, r_entry_inc);
                        end
                    end
                end

                c_st_clear: begin
                    r_buf[r_fill] <= c_space;
                    r_fill        <= r_fill + 5'd1;
                    if (r_fill == 5'd31) begin
                        r_cursor    <= 7'h00;
                        r_entry_inc <= 1'b1;
                        r_state     <= c_st_busy;
                        r_cnt       <= c_cnt_load;
                    end
                end

                c_st_busy: begin
                    if (r_cnt == '0) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data     = r_rd_data;
    assign cursor_addr = r_cursor;
    assign disp_on     = r_disp_on;
    assign entry_inc   = r_entry_inc;
    assign busy        = r_busy;
    assign ovr_err     = r_ovr_err;
    assign frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_hd44780_responder
// Purpose  : Self-checking bench for lcd_hd44780_responder. A table of
//            instruction/character vectors, hand-written timing and corner
//            sequences, and a randomized stream checked against a
//            behavioural model of the character buffer and cursor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_hd44780_responder;

    logic       clock;
    logic       iRST_N;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [6:0] cursor_addr;
    logic       disp_on;
    logic       entry_inc;
    logic       busy;
    logic       ovr_err;
    logic       frame_done;

    int total = 0;
    int bad   = 0;
    int fd_count = 0;

    // Behavioural model state
    logic [7:0] m_buf [32];
    int         m_cur;
    bit         m_inc;
    bit         m_disp;

    typedef struct {
        bit         rs;
        logic [7:0] data;
        int         cur;
        bit         disp;
        bit         inc;
    } vec_t;

    vec_t vec [21];

    lcd_hd44780_responder #(.BUSY_CYCLES(16)) dut (
        .clock       (clock),
        .iRST_N      (iRST_N),
        .LCD_DATA    (LCD_DATA),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_EN      (LCD_EN),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .cursor_addr (cursor_addr),
        .disp_on     (disp_on),
        .entry_inc   (entry_inc),
        .busy        (busy),
        .ovr_err     (ovr_err),
        .frame_done  (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_done === 1'b1) fd_count++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int m_step(input int a, input bit inc);
        if (inc) return (a == 39) ? 64 : (a == 103) ? 0 : (a + 1) % 128;
        else     return (a == 0) ? 103 : (a == 64) ? 39 : (a + 127) % 128;
    endfunction

    function automatic int m_idx(input int a);
        if (a < 16) return a;
        if (a >= 64 && a < 80) return a - 48;
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        m_cur = 0; m_inc = 1; m_disp = 0;
    endtask

    task automatic m_apply(input bit rs, input bit rw, input logic [7:0] d);
        int idx;
        if (rw) return;
        if (rs) begin
            idx = m_idx(m_cur);
            if (idx >= 0) m_buf[idx] = d;
            m_cur = m_step(m_cur, m_inc);
        end else if (d[7])        m_cur = int'(d[6:0]);
        else if (d[6] || d[5])    ;
        else if (d[4])            begin if (!d[3]) m_cur = m_step(m_cur, d[2]); end
        else if (d[3])            m_disp = d[2];
        else if (d[2])            m_inc = d[1];
        else if (d[1])            m_cur = 0;
        else if (d[0])            begin for (int i = 0; i < 32; i++) m_buf[i] = 8'h20; m_cur = 0; m_inc = 1; end
    endtask

    // Bus cycle: set-up 2 clocks, EN high 3 clocks, EN low with data held 3 clocks.
    task automatic strobe_raw(input bit rs, input bit rw, input logic [7:0] d);
        @(negedge clock);
        LCD_RS = rs; LCD_RW = rw; LCD_DATA = d;
        repeat (2) @(negedge clock);
        LCD_EN = 1'b1;
        repeat (3) @(negedge clock);
        LCD_EN = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy === 1'b0) begin done = 1; break; end
            @(negedge clock);
        end
        if (!done) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic send(input bit rs, input bit rw, input logic [7:0] d);
        strobe_raw(rs, rw, d);
        m_apply(rs, rw, d);
        wait_idle();
        chk("model_cursor", 32'(cursor_addr), 32'(m_cur));
        chk("model_disp", 32'(disp_on), 32'(m_disp));
        chk("model_inc", 32'(entry_inc), 32'(m_inc));
    endtask

    task automatic read_chk(input string name, input int idx, input logic [7:0] exp);
        @(negedge clock);
        rd_addr = 5'(idx);
        @(negedge clock);
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic check_buf_model(input string name);
        for (int i = 0; i < 32; i++) read_chk(name, i, m_buf[i]);
    endtask

    // Checks busy rise at k+2 and fall at k+2+n_busy, k = first edge seeing EN low.
    task automatic lat_check(input string name, input bit rs, input logic [7:0] d, input int n_busy);
        @(negedge clock);
        LCD_RS = rs; LCD_RW = 1'b0; LCD_DATA = d;
        repeat (2) @(negedge clock);
        LCD_EN = 1'b1;
        repeat (3) @(negedge clock);
        LCD_EN = 1'b0;
        @(posedge clock); #1;                     // edge k
        @(posedge clock); #1;                     // edge k+1
        chk({name, "_busy_k1"}, 32'(busy), 32'd0);
        @(posedge clock); #1;                     // edge k+2
        chk({name, "_busy_k2"}, 32'(busy), 32'd1);
        repeat (n_busy - 1) @(posedge clock);
        #1;
        chk({name, "_busy_last"}, 32'(busy), 32'd1);
        @(posedge clock); #1;
        chk({name, "_busy_fall"}, 32'(busy), 32'd0);
        m_apply(rs, 1'b0, d);
    endtask

    initial begin
        string s1, s2;
        logic [7:0] d;
        int r;

        s1 = "OUTPUT: 1234ABCD";
        s2 = "second line ok!!";

        vec[0] = '{0, 8'h38, 0, 0, 1};
        vec[1] = '{0, 8'h0C, 0, 1, 1};
        vec[2] = '{0, 8'h01, 0, 1, 1};
        vec[3] = '{0, 8'h06, 0, 1, 1};
        vec[4] = '{0, 8'h80, 0, 1, 1};
        for (int i = 0; i < 16; i++) vec[5 + i] = '{1, 8'(s1[i]), i + 1, 1, 1};

        LCD_EN = 0; LCD_RS = 0; LCD_RW = 0; LCD_DATA = 8'h00; rd_addr = 5'd0;
        iRST_N = 1'b0;
        m_reset();
        repeat (3) @(negedge clock);
        iRST_N = 1'b1;
        @(negedge clock);

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cursor", 32'(cursor_addr), 32'd0);
        chk("rst_inc", 32'(entry_inc), 32'd1);
        chk("rst_disp", 32'(disp_on), 32'd0);
        chk("rst_ovr", 32'(ovr_err), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        for (int i = 0; i < 32; i++) read_chk("rst_buf", i, 8'h20);

        // Strobe-to-busy latency for a character write and for a clear
        lat_check("lat_char", 1'b1, 8'h4C, 16);
        lat_check("lat_clear", 1'b0, 8'h01, 48);
        chk("lat_cursor", 32'(cursor_addr), 32'(m_cur));

        // Table: init sequence and line-1 text
        for (int i = 0; i < 21; i++) begin
            send(vec[i].rs, 1'b0, vec[i].data);
            chk("vec_cursor", 32'(cursor_addr), 32'(vec[i].cur));
            chk("vec_disp", 32'(disp_on), 32'(vec[i].disp));
            chk("vec_inc", 32'(entry_inc), 32'(vec[i].inc));
        end
        for (int i = 0; i < 16; i++) read_chk("line1_buf", i, 8'(s1[i]));
        chk("line1_cursor", 32'(cursor_addr), 32'h10);

        // Line 2 and frame_done
        fd_count = 0;
        send(1'b0, 1'b0, 8'hC0);
        for (int i = 0; i < 16; i++) send(1'b1, 1'b0, 8'(s2[i]));
        repeat (3) @(negedge clock);
        chk("line2_cursor", 32'(cursor_addr), 32'h50);
        chk("frame_done_count", 32'(fd_count), 32'd1);
        for (int i = 0; i < 16; i++) read_chk("line2_buf", 16 + i, 8'(s2[i]));

        // Wrap 0x67 -> 0x00, then index 23 via 0x47
        send(1'b0, 1'b0, 8'hE7);
        send(1'b1, 1'b0, 8'h58);
        chk("wrap_67_cursor", 32'(cursor_addr), 32'h00);
        send(1'b1, 1'b0, 8'h59);
        chk("wrap_y_cursor", 32'(cursor_addr), 32'h01);
        read_chk("wrap_idx0", 0, 8'h59);
        send(1'b0, 1'b0, 8'hC7);
        send(1'b1, 1'b0, 8'h58);
        read_chk("idx23", 23, 8'h58);

        // Decrement across 0x40 -> 0x27, with the 0x27 write dropped
        send(1'b0, 1'b0, 8'h04);
        send(1'b0, 1'b0, 8'hC0);
        send(1'b1, 1'b0, 8'h5A);
        chk("dec_wrap_cursor", 32'(cursor_addr), 32'h27);
        send(1'b1, 1'b0, 8'h5A);
        chk("dec_drop_cursor", 32'(cursor_addr), 32'h26);
        read_chk("idx16", 16, 8'h5A);
        chk("dec_inc", 32'(entry_inc), 32'd0);

        // Reads (RW = 1) are ignored entirely
        send(1'b1, 1'b1, 8'h51);
        chk("read_ignored_cursor", 32'(cursor_addr), 32'h26);
        chk("read_ignored_busy", 32'(busy), 32'd0);
        check_buf_model("after_wrap_buf");

        // Overrun: second strobe during busy is dropped
        chk("pre_ovr", 32'(ovr_err), 32'd0);
        send(1'b0, 1'b0, 8'h06);
        send(1'b0, 1'b0, 8'h85);
        strobe_raw(1'b1, 1'b0, 8'h50);
        m_apply(1'b1, 1'b0, 8'h50);
        repeat (2) @(negedge clock);
        strobe_raw(1'b1, 1'b0, 8'h57);
        wait_idle();
        chk("ovr_err_set", 32'(ovr_err), 32'd1);
        chk("ovr_cursor", 32'(cursor_addr), 32'h06);
        read_chk("ovr_idx5", 5, 8'h50);
        read_chk("ovr_idx6", 6, m_buf[6]);

        // Randomized stream against the model
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: send(1'b1, ($urandom_range(0, 9) == 0), 8'($urandom_range(33, 126)));
                4: send(1'b1, 1'b0, 8'($urandom));
                5: begin
                    case ($urandom_range(0, 2))
                        0: d = 8'h80 | 8'($urandom_range(0, 15));
                        1: d = 8'hC0 | 8'($urandom_range(0, 15));
                        default: d = 8'h80 | 8'($urandom_range(0, 127));
                    endcase
                    send(1'b0, 1'b0, d);
                end
                6: send(1'b0, 1'b0, 8'h04 | 8'($urandom_range(0, 3)));
                7: send(1'b0, 1'b0, 8'h10 | 8'($urandom_range(0, 15)));
                8: send(1'b0, 1'b0, 8'h08 | 8'($urandom_range(0, 7)));
                default: begin
                    case ($urandom_range(0, 5))
                        0: d = 8'h01;
                        1: d = 8'h02;
                        2: d = 8'h00;
                        3: d = 8'h20 | 8'($urandom_range(0, 31));
                        default: d = 8'h40 | 8'($urandom_range(0, 63));
                    endcase
                    send(1'b0, 1'b0, d);
                end
            endcase
        end
        check_buf_model("rand_buf");

        // Make line 2 non-blank, then reset in the middle of a clear
        send(1'b0, 1'b0, 8'h06);
        send(1'b0, 1'b0, 8'hCF);
        send(1'b1, 1'b0, 8'h41);
        strobe_raw(1'b0, 1'b0, 8'h01);
        repeat (8) @(negedge clock);
        #2;
        iRST_N = 1'b0;
        #1;
        chk("midclr_rst_busy", 32'(busy), 32'd0);
        chk("midclr_rst_ovr", 32'(ovr_err), 32'd0);
        chk("midclr_rst_cursor", 32'(cursor_addr), 32'd0);
        m_reset();
        repeat (2) @(negedge clock);
        iRST_N = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 32; i++) read_chk("midclr_buf", i, 8'h20);
        chk("midclr_inc", 32'(entry_inc), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
